// File: rtl/dpram_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dpram_wr_arbiter
// Purpose  : Round-robin arbiter merging NREQ valid/ready producer streams
//            into the single write port of the async FIFO's dual-port RAM.
//            A grant is held for up to BURST beats to keep packets contiguous
//            and a beat is only accepted when the RAM write actually lands.
// Revision : 1.0 - initial release
// ============================================================================
module dpram_wr_arbiter #(
  parameter int NREQ  = 4,
  parameter int DSIZE = 8,
  parameter int BURST = 4,
  localparam int IW   = $clog2(NREQ)
) (
  input  logic                  wclk,
  input  logic                  wrst_n,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*DSIZE-1:0] req_data,
  input  logic [NREQ-1:0]       req_last,
  output logic [NREQ-1:0]       req_ready,
  input  logic                  o_wfull,
  output logic                  wr_en,
  output logic [DSIZE-1:0]      wr_data,
  output logic [IW-1:0]         grant_id,
  output logic                  busy
);

  localparam int CW = $clog2(BURST) + 1;
  localparam logic [CW-1:0] C_LAST_BEAT = CW'(BURST - 1);
  localparam logic [IW-1:0] C_PTR_INIT  = IW'(NREQ - 1);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [IW-1:0]   r_rr_ptr;
  logic [IW-1:0]   w_rr_ptr_nxt;
  logic [IW-1:0]   r_grant_id;
  logic [IW-1:0]   w_grant_id_nxt;
  logic [CW-1:0]   r_beat_cnt;
  logic [CW-1:0]   w_beat_cnt_nxt;
  logic            w_any;
  logic [IW-1:0]   w_winner;
  logic            w_beat;

  // Cyclic search for the first valid requester after the last owner.
  always_comb begin
    int idx;
    idx      = 0;
    w_any    = 1'b0;
    w_winner = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = int'(r_rr_ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!w_any && req_valid[idx]) begin
        w_any    = 1'b1;
        w_winner = IW'(idx);
      end
    end
  end

  // Next-state logic plus the combinational write-port and ready outputs.
  always_comb begin
    int base;
    base           = int'(r_grant_id) * DSIZE;
    w_state_nxt    = r_state;
    w_rr_ptr_nxt   = r_rr_ptr;
    w_grant_id_nxt = r_grant_id;
    w_beat_cnt_nxt = r_beat_cnt;
    req_ready      = '0;
    w_beat         = 1'b0;
    wr_en          = 1'b0;
    wr_data        = '0;
    case (r_state)
      S_IDLE: begin
        // No beats here: this is the one-cycle arbitration bubble.
        if (w_any) begin
          w_state_nxt    = S_GRANT;
          w_grant_id_nxt = w_winner;
          w_rr_ptr_nxt   = w_winner;
          w_beat_cnt_nxt = '0;
        end
      end
      S_GRANT: begin
        req_ready[r_grant_id] = !o_wfull;
        w_beat = req_valid[r_grant_id] && !o_wfull;
        if (w_beat) begin
          wr_en   = 1'b1;
          wr_data = req_data[base +: DSIZE];
          if (req_last[r_grant_id] || (r_beat_cnt == C_LAST_BEAT)) begin
            w_state_nxt    = S_IDLE;
            w_beat_cnt_nxt = '0;
          end else begin
            w_beat_cnt_nxt = r_beat_cnt + CW'(1);
          end
        end else if (!req_valid[r_grant_id]) begin
          // Owner went idle: release so others are not starved.
          w_state_nxt    = S_IDLE;
          w_beat_cnt_nxt = '0;
        end
        // Otherwise the FIFO is full: hold the grant and the beat count.
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State and arbitration registers; pointer starts at NREQ-1 so 0 wins first.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      r_state    <= S_IDLE;
      r_rr_ptr   <= C_PTR_INIT;
      r_grant_id <= '0;
      r_beat_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_rr_ptr   <= w_rr_ptr_nxt;
      r_grant_id <= w_grant_id_nxt;
      r_beat_cnt <= w_beat_cnt_nxt;
    end
  end

  assign grant_id = r_grant_id;
  assign busy     = (r_state == S_GRANT);

endmodule
`default_nettype wire

// File: tb/tb_dpram_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dpram_wr_arbiter
// Purpose  : Self-checking bench for dpram_wr_arbiter against a transaction
//            level reference model (owner / beats-taken / last winner).
// Revision : 1.0 - initial release
// ============================================================================
module tb_dpram_wr_arbiter;

  localparam int NREQ  = 4;
  localparam int DSIZE = 8;
  localparam int BURST = 4;
  localparam int IW    = 2;

  logic                  wclk = 1'b0;
  logic                  wrst_n;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*DSIZE-1:0] req_data;
  logic [NREQ-1:0]       req_last;
  logic [NREQ-1:0]       req_ready;
  logic                  o_wfull;
  logic                  wr_en;
  logic [DSIZE-1:0]      wr_data;
  logic [IW-1:0]         grant_id;
  logic                  busy;

  int n_compared   = 0;
  int n_mismatched = 0;
  int beats_seen   = 0;

  // Reference model: current owner (-1 when none), beats taken, last winner.
  int m_owner;
  int m_taken;
  int m_last;

  dpram_wr_arbiter #(.NREQ(NREQ), .DSIZE(DSIZE), .BURST(BURST)) dut (
    .wclk      (wclk),
    .wrst_n    (wrst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .o_wfull   (o_wfull),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .grant_id  (grant_id),
    .busy      (busy)
  );

  always #5 wclk = ~wclk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_taken = 0;
    m_last  = NREQ - 1;
  endtask

  // Compare every output with what the model says for the current inputs.
  task automatic check_outputs();
    logic [NREQ-1:0]  e_ready;
    logic             e_beat;
    logic [DSIZE-1:0] e_data;
    e_ready = '0;
    e_beat  = 1'b0;
    e_data  = '0;
    if (m_owner >= 0) begin
      if (!o_wfull) e_ready[m_owner] = 1'b1;
      e_beat = req_valid[m_owner] && !o_wfull;
      if (e_beat) e_data = req_data[m_owner*DSIZE +: DSIZE];
    end
    check_eq("busy",      busy,      (m_owner >= 0));
    check_eq("req_ready", req_ready, e_ready);
    check_eq("wr_en",     wr_en,     e_beat);
    check_eq("wr_data",   wr_data,   e_data);
    if (m_owner >= 0) check_eq("grant_id", grant_id, m_owner);
    if (wr_en) beats_seen++;
  endtask

  // Advance the model by one clock edge using the current inputs.
  task automatic model_update();
    if (m_owner < 0) begin
      for (int k = 1; k <= NREQ; k++) begin
        int i;
        i = (m_last + k) % NREQ;
        if (m_owner < 0 && req_valid[i]) begin
          m_owner = i;
          m_last  = i;
          m_taken = 0;
        end
      end
    end else if (req_valid[m_owner] && !o_wfull) begin
      m_taken++;
      if (req_last[m_owner] || m_taken == BURST) begin
        m_owner = -1;
        m_taken = 0;
      end
    end else if (!req_valid[m_owner]) begin
      m_owner = -1;
      m_taken = 0;
    end
  endtask

  // Called just after a falling edge with inputs already driven.
  task automatic step();
    #1;
    check_outputs();
    @(posedge wclk);
    if (wrst_n) model_update();
    @(negedge wclk);
  endtask

  task automatic set_data_random();
    for (int i = 0; i < NREQ; i++) req_data[i*DSIZE +: DSIZE] = DSIZE'($urandom);
  endtask

  task automatic do_reset();
    wrst_n = 1'b0;
    model_reset();
    #1;
    check_eq("rst_busy",  busy,      1'b0);
    check_eq("rst_ready", req_ready, '0);
    check_eq("rst_wr_en", wr_en,     1'b0);
    check_eq("rst_data",  wr_data,   '0);
    check_eq("rst_gid",   grant_id,  '0);
    repeat (2) @(negedge wclk);
    wrst_n = 1'b1;
  endtask

  initial begin
    req_valid = '1;
    req_last  = '1;
    o_wfull   = 1'b0;
    set_data_random();
    model_reset();
    do_reset();

    // Round robin with single-beat packets: expect 0,1,2,3,0 with bubbles.
    for (int c = 0; c < 10; c++) begin
      set_data_random();
      step();
    end

    // Burst cap: requester 2 streams with no last; 3 waits its turn.
    do_reset();
    req_valid  = 4'b1100;
    req_last   = '0;
    beats_seen = 0;
    step();
    for (int c = 0; c < BURST; c++) begin
      set_data_random();
      step();
    end
    check_eq("burst_cap_beats", beats_seen, BURST);
    step();
    step();
    check_eq("after_cap_gid", grant_id, 3);

    // Full backpressure mid-burst on requester 1.
    do_reset();
    req_valid  = 4'b0010;
    req_last   = '0;
    beats_seen = 0;
    step();
    step();
    step();
    o_wfull = 1'b1;
    for (int c = 0; c < 5; c++) step();
    check_eq("bp_beats_held", beats_seen, 2);
    o_wfull = 1'b0;
    for (int c = 0; c < 3; c++) begin
      set_data_random();
      step();
    end
    check_eq("bp_total_beats", beats_seen, BURST);

    // Valid drop: requester 0 leaves after one beat, requester 1 takes over.
    do_reset();
    req_valid = 4'b0011;
    step();
    step();
    req_valid = 4'b0010;
    step();
    step();
    step();
    check_eq("vdrop_gid", grant_id, 1);

    // Reset during beat 3 of a burst from requester 2.
    do_reset();
    req_valid = 4'b0100;
    step();
    step();
    step();
    #1;
    check_outputs();
    #1;
    wrst_n = 1'b0;
    model_reset();
    #1;
    check_eq("midrst_wr_en", wr_en,     1'b0);
    check_eq("midrst_ready", req_ready, '0);
    check_eq("midrst_busy",  busy,      1'b0);
    @(negedge wclk);
    wrst_n    = 1'b1;
    req_valid = '1;
    req_last  = '1;
    step();
    step();
    check_eq("restart_gid", grant_id, 0);

    // Randomized traffic with random backpressure and packet ends.
    for (int c = 0; c < 600; c++) begin
      req_valid = NREQ'($urandom);
      req_last  = NREQ'($urandom) & NREQ'($urandom);
      o_wfull   = ($urandom_range(0, 3) == 0);
      set_data_random();
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dpram_wr_arbiter.md
Name: dpram_wr_arbiter

Overview:
- Round-robin write-port arbiter in the wclk domain of the async FIFO.
- Merges NREQ independent valid/ready producer streams into the single wr_en/wr_data write port of the FIFO's dual-port RAM.
- Holds each grant for a bounded burst to keep packets contiguous.
- Honours o_wfull, so no beat is accepted from a producer unless the RAM write actually lands.

Parameters:
- NREQ, 4, number of requesters (2..8).
- DSIZE, 8, data width per beat; matches FIFO DSIZE.
- BURST, 4, max consecutive beats per grant (1..16).
- IW, clog2(NREQ) (localparam), width of grant_id.

Ports:
- wclk  in  1  write-domain clock.
- wrst_n  in  1  asynchronous active-low reset.
- req_valid  in  NREQ  per-requester beat valid.
- req_data  in  NREQ*DSIZE  packed beat data; requester i in bits [i*DSIZE +: DSIZE].
- req_last  in  NREQ  marks the final beat of a requester's packet.
- req_ready  out  NREQ  per-requester accept; at most one bit high.
- o_wfull  in  1  FIFO full flag (wclk domain).
- wr_en  out  1  RAM/FIFO write enable.
- wr_data  out  DSIZE  RAM/FIFO write data.
- grant_id  out  IW  index of the current owner; valid when busy=1.
- busy  out  1  high while in GRANT.

Behaviour:
- Reset (async, wrst_n=0):
  - state=IDLE, rr_ptr=NREQ-1, beat_cnt=0, grant_id=0, busy=0.
  - req_ready=0, wr_en=0, wr_data=0. Reset mid-burst abandons the burst immediately.
- State machine, two states:
  - IDLE: if any req_valid is high, choose the first set bit searching cyclically from rr_ptr+1 (mod NREQ). Next edge: grant_id<=winner, rr_ptr<=winner, beat_cnt<=0, state<=GRANT. If none is valid, stay in IDLE. No beats are accepted in IDLE, giving a 1-cycle arbitration bubble.
  - GRANT, with g=grant_id:
    - req_ready[g] = !o_wfull (combinational); all other ready bits are 0.
    - beat = req_valid[g] && req_ready[g].
    - wr_en = beat and wr_data = req_data[g] (combinational, 0-cycle latency). wr_data = 0 when no beat.
    - On a beat with req_last[g]=1 or beat_cnt==BURST-1: state<=IDLE, beat_cnt<=0.
    - On any other beat: beat_cnt<=beat_cnt+1.
    - No beat because req_valid[g]=0: state<=IDLE (grant released).
    - No beat because o_wfull=1 while req_valid[g]=1: hold grant; beat_cnt is unchanged.
- busy = (state==GRANT), registered state.
- Fairness: after a release, the releasing requester has the lowest priority in the next IDLE evaluation.
  - Requests present in IDLE, then withdrawn before the edge, are not granted.
  - req_valid changes on non-granted requesters have no effect during GRANT.
- Ordering/integrity:
  - A beat is counted as transferred iff wr_en=1 on that edge.
  - wr_en is never high while o_wfull=1.
  - Data from a non-granted requester never reaches wr_data.
- Width rules:
  - beat_cnt width = clog2(BURST)+1.
  - rr_ptr wrap uses modulo NREQ, including non-power-of-2 NREQ; indices >= NREQ are never granted.
- Simultaneous events:
  - o_wfull rising in the same cycle as req_last: no beat; the grant is held until the last beat transfers.
  - wrst_n deassertion is synchronous-released externally; the first arbitration can occur on the first edge after release.

Test Plan:
- Reset: wrst_n=0 with all req_valid=1 -> req_ready=0, wr_en=0, busy=0. After release, first grant_id=0.
- Round robin: req_valid=4'b1111, all req_last=1, o_wfull=0 -> grants in order 0,1,2,3,0. Each single-beat grant is followed by a 1-cycle IDLE bubble. wr_data matches the granted slice.
- Burst cap: BURST=4, requester 2 continuous valid, req_last=0 -> exactly 4 consecutive wr_en pulses with grant_id=2, then release. If requester 3 is valid, it is granted next.
- Full backpressure: mid-burst on requester 1 after 2 beats, o_wfull=1 for 5 cycles -> req_ready[1]=0 and wr_en=0 for 5 cycles, beat_cnt held at 2. After o_wfull drops, 2 more beats, then release.
- Valid drop: granted requester 0 deasserts req_valid after 1 beat -> next edge returns to IDLE. Requester 1 (valid) is granted; requester 0 gets lowest priority.
- Reset mid-burst: wrst_n=0 asserted during beat 3 of a burst -> wr_en and req_ready go 0 immediately (async). After release, arbitration restarts from requester 0.
